// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
//   Shares a single-port backing memory between the instruction refill port
//   (i_, read only) and the data refill/write-back port (d_, read or write).
//   Each grant moves one aligned block of N = 2**BURST_LEN_LOG2 words.
//
//   Ports:
//     clk, rstn                  clock, asynchronous active-low reset
//     i_req, i_addr              instruction block request (held until i_done)
//     d_req, d_we, d_addr        data block request (held until d_done)
//     d_wdata                    write word for the current beat
//     i_gnt, d_gnt               port owns the memory (first strobe .. done)
//     i_rvalid, d_rvalid         rdata carries a read beat for that port
//     i_done, d_done             one-cycle burst completion pulse
//     d_wnext                    d_wdata consumed this cycle
//     rdata                      read data (straight from mem_rdata)
//     beat                       current write beat or returning read beat
//     busy                       arbiter not idle
//     mem_en, mem_we, mem_addr,
//     mem_wdata, mem_rdata       backing-memory interface (read latency MEM_LAT)
//
//   Handshake: a port raises req and holds it, with address/we stable, until
//   its done pulse; everything is latched on the IDLE edge that grants it and
//   later input changes are ignored. req must drop the cycle after done, a
//   request still high in IDLE starts a new burst.
//
//   Build option: define ARB_ROUND_ROBIN_EN to make ties alternate between
//   the ports; otherwise d always wins a tie.
module mem_burst_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN_LOG2 = 3,
    parameter int MEM_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      i_gnt,
    output logic                      d_gnt,
    output logic                      i_rvalid,
    output logic                      d_rvalid,
    output logic                      i_done,
    output logic                      d_done,
    output logic                      d_wnext,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [BURST_LEN_LOG2-1:0] beat,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int BL = BURST_LEN_LOG2;
    localparam int BW = ADDR_WIDTH - BURST_LEN_LOG2;
    localparam logic [BL-1:0] LAST_BEAT = {BL{1'b1}};

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                      state_q, state_d;
    logic                        owner_is_d_q, owner_is_d_d;
    logic [BW-1:0]               blk_q, blk_d;       // block-aligned upper address bits
    logic [BL-1:0]               cnt_q, cnt_d;       // issue / write beat counter
    logic                        issuing_q, issuing_d;
    // Read-return tracker: one valid bit and beat index per cycle of latency.
    logic [MEM_LAT-1:0]          vld_q, vld_d;
    logic [MEM_LAT-1:0][BL-1:0]  vbeat_q, vbeat_d;

    logic                        pick_d;
    logic                        strobe;
    logic                        ret_valid;
    logic [BL-1:0]               ret_beat;
    logic                        gnt;
    logic                        done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;
    // Tie goes to whichever port did not win the previous arbitration.
    assign pick_d = d_req && (!i_req || !last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign ret_valid = vld_q[MEM_LAT-1];
    assign ret_beat  = vbeat_q[MEM_LAT-1];
    assign rdata     = mem_rdata;

    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        blk_d        = blk_q;
        cnt_d        = cnt_q;
        issuing_d    = issuing_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d     = last_d_q;
`endif
        strobe    = 1'b0;
        gnt       = 1'b0;
        done      = 1'b0;
        d_wnext   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        beat      = '0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_is_d_d = pick_d;
                    blk_d        = pick_d ? d_addr[ADDR_WIDTH-1:BL] : i_addr[ADDR_WIDTH-1:BL];
                    cnt_d        = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d     = pick_d;
`endif
                    if (pick_d && d_we) begin
                        state_d = WR;
                    end else begin
                        state_d   = RD;
                        issuing_d = 1'b1;
                    end
                end
            end
            RD: begin
                gnt = 1'b1;
                if (issuing_q) begin
                    strobe   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = {blk_q, cnt_q};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        issuing_d = 1'b0;
                    end
                end
                if (ret_valid) begin
                    beat = ret_beat;
                end
                // The last returning beat closes the burst, so no return
                // belonging to this owner can leak into the next grant.
                if (ret_valid && ret_beat == LAST_BEAT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                gnt       = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {blk_q, cnt_q};
                mem_wdata = d_wdata;
                d_wnext   = 1'b1;
                beat      = cnt_q;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d      = '0;
        vbeat_d    = '0;
        vld_d[0]   = strobe;
        vbeat_d[0] = cnt_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            vbeat_d[i] = vbeat_q[i-1];
        end
    end

    assign busy     = (state_q != IDLE);
    assign i_gnt    = gnt && !owner_is_d_q;
    assign d_gnt    = gnt && owner_is_d_q;
    assign i_rvalid = (state_q == RD) && ret_valid && !owner_is_d_q;
    assign d_rvalid = (state_q == RD) && ret_valid && owner_is_d_q;
    assign i_done   = done && !owner_is_d_q;
    assign d_done   = done && owner_is_d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_is_d_q <= 1'b0;
            blk_q        <= '0;
            cnt_q        <= '0;
            issuing_q    <= 1'b0;
            vld_q        <= '0;
            vbeat_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            blk_q        <= blk_d;
            cnt_q        <= cnt_d;
            issuing_q    <= issuing_d;
            vld_q        <= vld_d;
            vbeat_q      <= vbeat_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value "last grant was i" makes d the favoured port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter
//   Directed bench for mem_burst_arbiter with default parameters
//   (N = 8 words per burst, read latency 2). Inputs are driven 1 time unit
//   after the rising edge, outputs are sampled on the falling edge.
module tb_mem_burst_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BL  = 3;
    localparam int LAT = 2;
    localparam int N   = 1 << BL;

    logic          clk;
    logic          rstn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, d_wnext;
    logic [DW-1:0] rdata;
    logic [BL-1:0] beat;
    logic          busy, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total;
    int bad;

    mem_burst_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_LOG2(BL), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
        .i_done(i_done), .d_done(d_done),
        .d_wnext(d_wnext), .rdata(rdata), .beat(beat), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] obs_ctl();
        return {i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done,
                d_wnext, busy, mem_en, mem_we};
    endfunction

    // Runs one burst (segment A, starting in cycle 0) and optionally a second
    // one (segment B) whose IDLE arbitration cycle is b_start. Each segment's
    // owner holds req through its done cycle. Expected values come from the
    // cycle-relative timing of a read (strobes 1..N, returns 1+LAT..N+LAT)
    // or a write (strobes 1..N, done N).
    task automatic burst_seq(input string tag,
                             input bit a_rd, input bit a_pd, input logic [AW-1:0] a_base,
                             input bit has_b,
                             input bit b_rd, input bit b_pd, input logic [AW-1:0] b_base,
                             input int b_start);
        int done_a, done_b, last_c;
        done_a = a_rd ? N + LAT : N;
        done_b = has_b ? b_start + (b_rd ? N + LAT : N) : 0;
        last_c = has_b ? done_b + 1 : done_a + 1;
        @(posedge clk); #1;
        for (int c = 0; c <= last_c; c++) begin
            int s, dn;
            bit rd, pd, str, rv, g, dd, a_on, b_on;
            logic [AW-1:0] base;
            logic [9:0] exp_ctl;
            logic [AW-1:0] exp_addr;
            logic [BL-1:0] exp_beat;
            logic [DW-1:0] exp_wdata;
            // drive
            a_on = (c <= done_a);
            b_on = has_b && (c <= done_b);
            i_req = (a_on && !a_pd) || (b_on && !b_pd);
            d_req = (a_on && a_pd) || (b_on && b_pd);
            if (!a_pd && c == 0)       i_addr = a_base;
            else if (has_b && !b_pd)   i_addr = b_base;
            else                       i_addr = AW'($urandom);
            if (a_pd && c == 0)        begin d_addr = a_base; d_we = !a_rd; end
            else if (has_b && b_pd)    begin d_addr = b_base; d_we = !b_rd; end
            else                       begin d_addr = AW'($urandom); d_we = 1'($urandom); end
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            // expected
            if (has_b && c >= b_start) begin
                s = c - b_start; rd = b_rd; pd = b_pd; base = b_base;
            end else begin
                s = c; rd = a_rd; pd = a_pd; base = a_base;
            end
            dn  = rd ? N + LAT : N;
            str = (s >= 1) && (s <= N);
            rv  = rd && (s >= 1 + LAT) && (s <= N + LAT);
            g   = (s >= 1) && (s <= dn);
            dd  = (s == dn);
            exp_ctl   = {g && !pd, g && pd, rv && !pd, rv && pd, dd && !pd, dd && pd,
                         !rd && str, g, str, !rd && str};
            exp_addr  = str ? {base[AW-1:BL], BL'(s - 1)} : '0;
            exp_beat  = rd ? (rv ? BL'(s - 1 - LAT) : '0) : (str ? BL'(s - 1) : '0);
            exp_wdata = (!rd && str) ? d_wdata : '0;
            @(negedge clk);
            total++;
            if (obs_ctl() !== exp_ctl) begin
                bad++;
                $display("FAIL %s ctl cycle %0d: got %b expected %b (gnt_i,gnt_d,rv_i,rv_d,dn_i,dn_d,wnext,busy,en,we)",
                         tag, c, obs_ctl(), exp_ctl);
            end
            total++;
            if (mem_addr !== exp_addr) begin
                bad++;
                $display("FAIL %s mem_addr cycle %0d: got %h expected %h", tag, c, mem_addr, exp_addr);
            end
            total++;
            if (beat !== exp_beat) begin
                bad++;
                $display("FAIL %s beat cycle %0d: got %0d expected %0d", tag, c, beat, exp_beat);
            end
            total++;
            if (mem_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL %s mem_wdata cycle %0d: got %h expected %h", tag, c, mem_wdata, exp_wdata);
            end
            total++;
            if (rdata !== mem_rdata) begin
                bad++;
                $display("FAIL %s rdata cycle %0d: got %h expected %h", tag, c, rdata, mem_rdata);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            total++;
            if (obs_ctl() !== 10'b0 || mem_addr !== '0 || beat !== '0 || mem_wdata !== '0) begin
                bad++;
                $display("FAIL reset outputs: ctl=%b addr=%h beat=%0d wdata=%h expected all zero",
                         obs_ctl(), mem_addr, beat, mem_wdata);
            end
            total++;
            if (rdata !== mem_rdata) begin
                bad++;
                $display("FAIL reset rdata: got %h expected %h", rdata, mem_rdata);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_instr_read();
        burst_seq("instr_read", 1'b1, 1'b0, 10'h05B, 1'b0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_data_write();
        burst_seq("data_write", 1'b0, 1'b1, 10'h120, 1'b0, 1'b0, 1'b0, '0, 0);
    endtask

    // The previous burst was a d grant, so round-robin lets i win the tie.
    task automatic test_tie();
`ifdef ARB_ROUND_ROBIN_EN
        burst_seq("tie_rr", 1'b1, 1'b0, 10'h040, 1'b1, 1'b1, 1'b1, 10'h200, N + LAT + 1);
`else
        burst_seq("tie_fixed", 1'b1, 1'b1, 10'h200, 1'b1, 1'b1, 1'b0, 10'h040, N + LAT + 1);
`endif
    endtask

    task automatic test_addr_wrap();
        burst_seq("addr_wrap", 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_back_to_back();
        burst_seq("held_req", 1'b1, 1'b0, 10'h300, 1'b1, 1'b1, 1'b0, 10'h310, N + LAT + 1);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 10'h080;           // cycle 0
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;                   // now in cycle c
        end
        // cycle 4: beat 1 is returning, reset hits asynchronously
        total++;
        if (i_rvalid !== 1'b1 || beat !== 3'd1) begin
            bad++;
            $display("FAIL mid_reset pre: i_rvalid=%b beat=%0d expected 1 and 1", i_rvalid, beat);
        end
        rstn = 1'b0;
        i_req = 1'b0;
        #1;
        total++;
        if (obs_ctl() !== 10'b0 || mem_addr !== '0 || beat !== '0) begin
            bad++;
            $display("FAIL mid_reset immediate: ctl=%b addr=%h beat=%0d expected all zero",
                     obs_ctl(), mem_addr, beat);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (obs_ctl() !== 10'b0) begin
                bad++;
                $display("FAIL mid_reset hold %0d: ctl=%b expected 0", k, obs_ctl());
            end
        end
        rstn = 1'b1;                              // released on a falling edge
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (obs_ctl() !== 10'b0) begin
                bad++;
                $display("FAIL mid_reset after release %0d: ctl=%b expected 0", k, obs_ctl());
            end
        end
        burst_seq("restart", 1'b1, 1'b0, 10'h0C8, 1'b0, 1'b0, 1'b0, '0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_instr_read();
        test_data_write();
        test_tie();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
